// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
// Segment order is {a,b,c,d,e,f,g} with a in bit 6; patterns are active-high.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

   // Index n holds the glyph for hex code n (entries listed from F down to 0).
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
      7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
      7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
      7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
   };

   function automatic logic [6:0] seg_apply_pol(input logic [6:0] seg,
                                                input logic       active_low);
      return active_low ? ~seg : seg;
   endfunction

endpackage

// File: rtl/seg7_hex_seg_decode.sv
// Combinational hex code to 7-segment lookup with a blanking override.
module hex_seg_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   assign seg_o = blank_i ? SEG_OFF : HEX_SEG_TABLE[code_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: frame-synchronous input snapshot,
// per-digit slot scan with a blank gap, leading-zero suppression and polarity control.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS       = 4,
   parameter int unsigned PRESCALE       = 50000,
   parameter int unsigned BLANK_CYCLES   = 2,
   parameter int unsigned SEG_ACTIVE_LOW = 0,
   parameter int unsigned DIG_ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_in,
   input  logic                  lzs_en,
   output logic [6:0]            seg_data,
   output logic                  seg_dp,
   output logic [N_DIGITS-1:0]   digit_en,
   output logic                  frame_start
);

   localparam int unsigned CNT_W = $clog2(PRESCALE);
   localparam int unsigned IDX_W = $clog2(N_DIGITS);
   localparam logic        SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] DIG_MASK = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [N_DIGITS-1:0]   blank_sh_q, blank_sh_d;
   logic                  lzs_sh_q, lzs_sh_d;
   logic                  load_q, load_d;
   logic [6:0]            seg_q;
   logic                  dp_q;
   logic [N_DIGITS-1:0]   dig_q;
   logic                  fs_q;

   logic                  slot_end, frame_end, load_now;
   logic [N_DIGITS-1:0]   supp;
   logic                  higher_dark, code_zero;
   logic [3:0]            cur_code;
   logic                  cur_blank, cur_supp, cur_dp, cur_dark;
   logic [6:0]            dec_seg;
   logic [N_DIGITS-1:0]   dig_raw;

   // Slot/digit sequencing and shadow capture.
   always_comb begin
      slot_end   = (cnt_q == CNT_W'(PRESCALE - 1));
      frame_end  = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));
      load_now   = load_q || frame_end;
      cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (slot_end) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
      data_sh_d  = load_now ? data_in  : data_sh_q;
      dp_sh_d    = load_now ? dp_in    : dp_sh_q;
      blank_sh_d = load_now ? blank_in : blank_sh_q;
      lzs_sh_d   = load_now ? lzs_en   : lzs_sh_q;
      load_d     = 1'b0;
   end

   // A zero is suppressed while everything above it is zero or blanked.
   always_comb begin
      supp        = '0;
      higher_dark = 1'b1;
      code_zero   = 1'b0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         code_zero   = (data_sh_q[4*i +: 4] == 4'h0);
         supp[i]     = lzs_sh_q && code_zero && higher_dark;
         higher_dark = higher_dark && (code_zero || blank_sh_q[i]);
      end
   end

   always_comb begin
      cur_code  = 4'h0;
      cur_blank = 1'b0;
      cur_supp  = 1'b0;
      cur_dp    = 1'b0;
      dig_raw   = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_code   = data_sh_q[4*i +: 4];
            cur_blank  = blank_sh_q[i];
            cur_supp   = supp[i];
            cur_dp     = dp_sh_q[i];
            dig_raw[i] = (cnt_q >= CNT_W'(BLANK_CYCLES));
         end
      end
      cur_dark = cur_blank || cur_supp;
   end

   hex_seg_decode u_dec (
      .code_i  (cur_code),
      .blank_i (cur_dark),
      .seg_o   (dec_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         data_sh_q  <= '0;
         dp_sh_q    <= '0;
         blank_sh_q <= '0;
         lzs_sh_q   <= 1'b0;
         load_q     <= 1'b1;
         seg_q      <= seg_apply_pol(SEG_OFF, SEG_INV);
         dp_q       <= SEG_INV;
         dig_q      <= DIG_MASK;
         fs_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         data_sh_q  <= data_sh_d;
         dp_sh_q    <= dp_sh_d;
         blank_sh_q <= blank_sh_d;
         lzs_sh_q   <= lzs_sh_d;
         load_q     <= load_d;
         seg_q      <= seg_apply_pol(dec_seg, SEG_INV);
         dp_q       <= (cur_dp && !cur_blank) ^ SEG_INV;
         dig_q      <= dig_raw ^ DIG_MASK;
         fs_q       <= load_now;
      end
   end

   assign seg_data    = seg_q;
   assign seg_dp      = dp_q;
   assign digit_en    = dig_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: N=4, PRESCALE=8, BLANK_CYCLES=2, with an
// active-high instance and an inverted-polarity instance sharing all inputs.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lzs_en;

   logic [6:0]  seg_data, seg_data_n;
   logic        seg_dp, seg_dp_n;
   logic [3:0]  digit_en, digit_en_n;
   logic        frame_start, frame_start_n;

   int tests = 0;
   int fails = 0;

   seg7_scan_driver #(
      .N_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2),
      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
      .blank_in(blank_in), .lzs_en(lzs_en), .seg_data(seg_data),
      .seg_dp(seg_dp), .digit_en(digit_en), .frame_start(frame_start)
   );

   seg7_scan_driver #(
      .N_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2),
      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) dut_n (
      .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
      .blank_in(blank_in), .lzs_en(lzs_en), .seg_data(seg_data_n),
      .seg_dp(seg_dp_n), .digit_en(digit_en_n), .frame_start(frame_start_n)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_inactive(input string tag);
      check({tag, " seg"},    {25'd0, seg_data},    32'h00);
      check({tag, " dp"},     {31'd0, seg_dp},      32'h0);
      check({tag, " en"},     {28'd0, digit_en},    32'h0);
      check({tag, " fs"},     {31'd0, frame_start}, 32'h0);
      check({tag, " seg_n"},  {25'd0, seg_data_n},  32'h7f);
      check({tag, " dp_n"},   {31'd0, seg_dp_n},    32'h1);
      check({tag, " en_n"},   {28'd0, digit_en_n},  32'hf);
   endtask

   // Walks the 8 output cycles of one digit slot.
   task automatic check_slot(input int f, input int d, input logic [6:0] exp_seg,
                             input logic exp_dp, input logic first);
      logic [3:0] exp_en, exp_en_n;
      logic [6:0] exp_seg_n;
      logic       exp_fs, exp_dp_n;
      string      tag;
      for (int k = 0; k < 8; k++) begin
         step();
         exp_en    = (k >= 2) ? 4'(1 << d) : 4'b0000;
         exp_en_n  = ~exp_en;
         exp_seg_n = ~exp_seg;
         exp_dp_n  = ~exp_dp;
         exp_fs    = (first && k == 0) || (d == 3 && k == 7);
         tag = $sformatf("f%0d d%0d k%0d", f, d, k);
         check({tag, " digit_en"},    {28'd0, digit_en},    {28'd0, exp_en});
         check({tag, " digit_en_n"},  {28'd0, digit_en_n},  {28'd0, exp_en_n});
         check({tag, " frame_start"}, {31'd0, frame_start}, {31'd0, exp_fs});
         if (k >= 2) begin
            check({tag, " seg_data"},   {25'd0, seg_data},   {25'd0, exp_seg});
            check({tag, " seg_dp"},     {31'd0, seg_dp},     {31'd0, exp_dp});
            check({tag, " seg_data_n"}, {25'd0, seg_data_n}, {25'd0, exp_seg_n});
            check({tag, " seg_dp_n"},   {31'd0, seg_dp_n},   {31'd0, exp_dp_n});
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      data_in  = 16'h1234;
      dp_in    = 4'b0000;
      blank_in = 4'b0000;
      lzs_en   = 1'b0;
      repeat (3) step();
      check_inactive("reset");
      rst = 1'b0;

      // Scan order: digits 4,3,2,1 from right to left.
      check_slot(1, 0, 7'b0110011, 1'b0, 1'b1);
      check_slot(1, 1, 7'b1111001, 1'b0, 1'b0);
      check_slot(1, 2, 7'b1101101, 1'b0, 1'b0);
      check_slot(1, 3, 7'b0110000, 1'b0, 1'b0);
      check_slot(2, 0, 7'b0110011, 1'b0, 1'b0);
      check_slot(2, 1, 7'b1111001, 1'b0, 1'b0);
      check_slot(2, 2, 7'b1101101, 1'b0, 1'b0);
      data_in = 16'h00A0;
      lzs_en  = 1'b1;
      check_slot(2, 3, 7'b0110000, 1'b0, 1'b0);

      // Hex A with leading zeros suppressed.
      check_slot(3, 0, 7'b1111110, 1'b0, 1'b0);
      check_slot(3, 1, 7'b1110111, 1'b0, 1'b0);
      check_slot(3, 2, 7'b0000000, 1'b0, 1'b0);
      lzs_en = 1'b0;
      check_slot(3, 3, 7'b0000000, 1'b0, 1'b0);

      // Same value, suppression off.
      check_slot(4, 0, 7'b1111110, 1'b0, 1'b0);
      check_slot(4, 1, 7'b1110111, 1'b0, 1'b0);
      check_slot(4, 2, 7'b1111110, 1'b0, 1'b0);
      data_in = 16'h1111;
      check_slot(4, 3, 7'b1111110, 1'b0, 1'b0);

      // Mid-frame input change must wait for the next frame.
      check_slot(5, 0, 7'b0110000, 1'b0, 1'b0);
      check_slot(5, 1, 7'b0110000, 1'b0, 1'b0);
      data_in = 16'h2222;
      check_slot(5, 2, 7'b0110000, 1'b0, 1'b0);
      check_slot(5, 3, 7'b0110000, 1'b0, 1'b0);
      check_slot(6, 0, 7'b1101101, 1'b0, 1'b0);
      check_slot(6, 1, 7'b1101101, 1'b0, 1'b0);
      check_slot(6, 2, 7'b1101101, 1'b0, 1'b0);
      data_in  = 16'h8888;
      blank_in = 4'b0100;
      dp_in    = 4'b0101;
      check_slot(6, 3, 7'b1101101, 1'b0, 1'b0);

      // Blanking overrides the decimal point; dp shows on unblanked digit 0.
      check_slot(7, 0, 7'b1111111, 1'b1, 1'b0);
      check_slot(7, 1, 7'b1111111, 1'b0, 1'b0);
      check_slot(7, 2, 7'b0000000, 1'b0, 1'b0);
      data_in  = 16'h0000;
      blank_in = 4'b0000;
      dp_in    = 4'b0100;
      lzs_en   = 1'b1;
      check_slot(7, 3, 7'b1111111, 1'b0, 1'b0);

      // All zeros suppressed except digit 0; suppressed digit 2 keeps its dp.
      check_slot(8, 0, 7'b1111110, 1'b0, 1'b0);
      check_slot(8, 1, 7'b0000000, 1'b0, 1'b0);
      check_slot(8, 2, 7'b0000000, 1'b1, 1'b0);
      check_slot(8, 3, 7'b0000000, 1'b0, 1'b0);

      // Advance to cnt=5, idx=2 and hit reset between clock edges.
      repeat (21) step();
      check("pre-reset digit_en", {28'd0, digit_en}, 32'h4);
      #1;
      rst = 1'b1;
      #1;
      check_inactive("async reset");
      data_in  = 16'h5678;
      dp_in    = 4'b0000;
      lzs_en   = 1'b0;
      repeat (2) step();
      check_inactive("reset held");
      rst = 1'b0;
      check_slot(9, 0, 7'b1111111, 1'b0, 1'b1);
      check_slot(9, 1, 7'b1110000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed N-digit 7-segment display driver, the multi-digit successor to the single-digit BCD decoder. Snapshots a packed vector of 4-bit digit codes once per frame, then scans the digits one at a time. For each digit it drives the shared segment bus and one digit enable. It adds hex decoding (0–F), per-digit blanking, decimal points, leading-zero suppression, an anti-ghosting blank gap and selectable output polarity. It sits between the counter/datapath logic and the board display pins.

## Interface
- N_DIGITS, 4: number of multiplexed digits; ≥2.
- PRESCALE, 50000: clk cycles per digit slot; ≥2.
- BLANK_CYCLES, 2: cycles at the start of each slot with all digit enables inactive; 0 ≤ BLANK_CYCLES < PRESCALE.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_data and seg_dp.
- DIG_ACTIVE_LOW, 0: 1 inverts digit_en.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- data_in, in, 4*N_DIGITS: digit codes; digit i = data_in[4i+3:4i]; digit 0 is the rightmost (LSB) digit.
- dp_in, in, N_DIGITS: decimal point request per digit.
- blank_in, in, N_DIGITS: force digit i dark (segments and dp).
- lzs_en, in, 1: leading-zero suppression enable.
- seg_data, out, 7: segments {a,b,c,d,e,f,g}, a = bit 6, g = bit 0.
- seg_dp, out, 1: decimal point segment.
- digit_en, out, N_DIGITS: one-hot digit enable.
- frame_start, out, 1: one-cycle pulse when the shadow registers load.

## Operation
- Internal state: slot counter cnt (0..PRESCALE-1), digit index idx (0..N_DIGITS-1), shadow registers for data_in/dp_in/blank_in/lzs_en, and a load flag.
- Each cycle, cnt increments. On cnt = PRESCALE-1, cnt wraps to 0 and idx advances; idx wraps from N_DIGITS-1 to 0.
- Shadow load happens on the first cycle after reset deassertion, and on every cnt wrap where idx goes N_DIGITS-1 → 0.
  - Inputs are sampled in that cycle and frame_start pulses in the same cycle.
  - Input changes between loads have no visible effect, so there is no tearing.
- Decode uses true hex patterns, active-high: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero suppression (shadow lzs_en = 1):
  - Digit i is suppressed if its code is 0 and every higher digit is either 0 or blanked.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its dp if requested.
- Dark digit: a blanked or suppressed digit gives seg_data all inactive. seg_dp is inactive when blanked; when suppressed it follows dp_in.
- digit_en[idx] is active when cnt ≥ BLANK_CYCLES; all enables are inactive otherwise. The segment outputs show the current idx for the whole slot.
- Polarity inversion is applied at the output registers only.

## Timing
- All outputs are registered and reflect the cnt/idx/shadow state of the previous cycle.
- Reset values (asynchronous):
  - Internal: cnt = 0, idx = 0, shadow registers = 0, load flag set.
  - Outputs: seg_data, seg_dp and digit_en all at their inactive level (0 when active-high, all-ones when active-low); frame_start = 0.
- First slot after reset release: digit 0 shows a code sampled in the first clk after release. digit_en[0] first goes active at output cycle BLANK_CYCLES+1.
- Slot length is exactly PRESCALE cycles. Frame length is N_DIGITS*PRESCALE cycles. frame_start period equals the frame length.
- Reset mid-scan: outputs go inactive immediately and the scan restarts at digit 0 with a fresh load.
- Fixed boundary behaviours:
  - BLANK_CYCLES = 0 gives no gap.
  - digit_en is never more than one-hot.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex segment constant table;
  - SEG_OFF = 7'b0000000;
  - a function seg_apply_pol(seg, active_low).
- Sub-module hex_seg_decode: combinational 4-bit → 7-bit lookup using the package table, with a blank input. Instantiated once, on the muxed digit.

## Test plan
Parameters for all scenarios: N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, active-high.
- Scan order: data_in=16'h1234 held from reset.
  - Required: digit_en sequence 0001, 0010, 0100, 1000; seg_data = 0110011, 1111001, 1101101, 0110000 (digits 4, 3, 2, 1).
  - Required: each digit enable active 6 of 8 cycles; frame_start every 32 cycles.
- Hex and leading zeros: data_in=16'h00A0, lzs_en=1.
  - Required: digits 3 and 2 dark; digit 1 = 1110111; digit 0 = 1111110.
  - With lzs_en=0, digits 3 and 2 show 1111110.
- Tear-free update: data_in changed 16'h1111 → 16'h2222 mid-frame.
  - Required: the remaining slots of that frame still show 1; 2 appears only after the next frame_start.
- Blank and decimal point: blank_in=4'b0100, dp_in=4'b0101, data_in=16'h8888.
  - Required: digit 2 has seg_data=0 and seg_dp=0; digit 0 has seg_dp=1; other digits show 1111111.
- Async reset mid-slot (cnt=5, idx=2), plus polarity variant.
  - Required: outputs inactive in the same cycle; the scan restarts at digit 0.
  - Required: with SEG_ACTIVE_LOW=1 and DIG_ACTIVE_LOW=1, reset outputs are seg_data=1111111, seg_dp=1, digit_en=1111.
